// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame constants and default timings.
// Both the host transmitter and the keyboard receiver import this package.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5,
    ACK       = 3'd6,
    WAIT_IDLE = 3'd7
  } state_t;

  // Device falling edges in one host-to-device frame (8 data, parity, stop, ack).
  localparam int NUM_FALLS = 11;
  localparam int DATA_BITS = 8;

  // Defaults for the 48 MHz fast clock.
  localparam int DEF_INHIBIT_CYCLES = 5760;    // 120 us
  localparam int DEF_TIMEOUT_CYCLES = 720000;  // 15 ms
  localparam int DEF_CNT_W          = 20;

  // Odd parity: the bit that makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus falling-edge detect.
// Flops reset to 1 (released line) so reset never produces a false edge.
module ps2_line_sync (
  input  logic clk,
  input  logic clr,
  input  logic line,
  output logic synced,
  output logic fall
);

  // sr[0]: first stage, sr[1]: synchronized value, sr[2]: previous synchronized value
  logic [2:0] sr;

  // Shift the raw line through the synchronizer and history stage.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) sr <= 3'b111;
    else     sr <= {sr[1:0], line};
  end

  assign synced = sr[1];
  assign fall   = sr[2] & ~sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shift on
// device falling edges, ACK sample, then wait for an idle bus.
//
// Handshake: a byte transfers on any clk edge where tx_valid and tx_ready are
// both 1. tx_ready is 1 only in IDLE, so tx_data is sampled exactly once per
// frame and tx_valid is ignored while the frame is in flight.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       ack_ok,
  output logic       ack_err
);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LAST_DATA_FALL = 4'(DATA_BITS);
  localparam logic [3:0]       STOP_FALL      = 4'(NUM_FALLS - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;        // inhibit length, then time since last device fall
  logic [3:0]       idx;        // device falling edges seen so far
  logic [9:0]       shreg;      // {stop, parity, D7..D0}; bit 0 is on the wire
  logic             started;    // holds tx_ready low until the first edge after reset
  logic             to_pulse;   // ack_err strobe for a timed-out frame
  logic             clk_s, clk_fall;
  logic             data_s, data_fall_unused;
  logic             accept, timeout, in_frame;

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .clr    (clr),
    .line   (ps2_clk_in),
    .synced (clk_s),
    .fall   (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk    (clk),
    .clr    (clr),
    .line   (ps2_data_in),
    .synced (data_s),
    .fall   (data_fall_unused)
  );

  assign accept   = tx_valid && tx_ready;
  assign timeout  = (cnt == TO_LAST);
  assign in_frame = (state == REQ) || (state == DATA) || (state == PARITY) || (state == STOP);

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a timeout wins over a coincident device edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = INHIBIT;
      INHIBIT:   if (cnt == INH_LAST) state_next = REQ;
      REQ:       if (timeout) state_next = WAIT_IDLE;
                 else if (clk_fall) state_next = DATA;
      DATA:      if (timeout) state_next = WAIT_IDLE;
                 else if (clk_fall && idx == LAST_DATA_FALL) state_next = PARITY;
      PARITY:    if (timeout) state_next = WAIT_IDLE;
                 else if (clk_fall) state_next = STOP;
      STOP:      if (timeout) state_next = WAIT_IDLE;
                 else if (clk_fall && idx == STOP_FALL) state_next = ACK;
      ACK:       state_next = WAIT_IDLE;
      WAIT_IDLE: if (clk_s && data_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath: byte latch, shared saturating counter, fall index, timeout strobe.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '1;
      started  <= 1'b0;
      to_pulse <= 1'b0;
    end else begin
      started  <= 1'b1;
      to_pulse <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          shreg <= {1'b1, odd_parity(tx_data), tx_data};
          cnt   <= '0;
          idx   <= '0;
        end
      end else if (state == INHIBIT) begin
        cnt <= (cnt == INH_LAST) ? '0 : cnt + 1'b1;
      end else if (in_frame) begin
        if (timeout) begin
          to_pulse <= 1'b1;
        end else if (clk_fall) begin
          cnt <= '0;
          idx <= idx + 4'd1;
          // The first fall presents D0, already at bit 0; later falls advance.
          if (state != REQ) shreg <= {1'b1, shreg[9:1]};
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Outputs decoded from state; data_oe pulls low for a 0 bit.
  always_comb begin
    tx_ready    = started && (state == IDLE);
    busy        = (state != IDLE);
    ps2_clk_oe  = (state == INHIBIT);
    ps2_data_oe = 1'b0;
    ack_ok      = 1'b0;
    ack_err     = to_pulse;
    case (state)
      INHIBIT:      ps2_data_oe = (cnt == INH_LAST);
      REQ:          ps2_data_oe = 1'b1;
      DATA, PARITY: ps2_data_oe = ~shreg[0];
      ACK: begin
        ack_ok  = ~data_s;
        ack_err = data_s;
      end
      default:      ps2_data_oe = 1'b0;
    endcase
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter: the write direction of the keyboard link, used to send commands such as 0xED (set LEDs) or 0xFF (reset) to the keyboard. It accepts one byte per valid/ready handshake and performs the inhibit / request-to-send / bit-shift / ACK sequence on open-drain PS/2 lines. It runs on the 48 MHz fast clock next to the keyboard receiver. Its busy output gates that receiver during a transmission.

Parameters:
INHIBIT_CYCLES, 5760, clocks ps2_clk is held low before request-to-send (120 us at 48 MHz)
TIMEOUT_CYCLES, 720000, max clocks between device falling edges before abort (15 ms)
CNT_W, 20, width of the shared cycle counter; must satisfy 2^CNT_W > max(INHIBIT_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock (fast_clk, 48 MHz)
clr  in  1  asynchronous reset, active-high
tx_data  in  8  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept a byte
ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
ps2_data_in  in  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release
ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release
busy  out  1  transmission in progress; receiver must ignore the bus
ack_ok  out  1  one-cycle pulse: device ACKed
ack_err  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Clock: single clock domain. Reset: asynchronous, active-high. While clr is high: state IDLE, all outputs 0, both lines released, tx_ready 0. tx_ready rises on the first clk edge after clr falls.
- Line inputs: 2-FF synchronizer on each. clk_fall = previous synced value 1 and current synced value 0. The edge is seen 3 clocks after the pin toggles.
- Handshake: a byte is accepted on the cycle tx_valid & tx_ready. That cycle latches the byte and the odd parity bit (~^tx_data). tx_ready is 1 only in IDLE. tx_valid while busy is ignored and tx_data is not sampled.
- busy = 1 in every state except IDLE.
- IDLE: both lines released. On accept -> INHIBIT; counter cleared.
- INHIBIT: ps2_clk_oe = 1. When counter = INHIBIT_CYCLES-1, set ps2_data_oe = 1 (start bit) -> REQ. The start bit overlaps the last inhibit cycle.
- REQ: ps2_clk_oe = 0 and ps2_data_oe = 1. Wait for device clk_fall.
- Bit sequence: a 4-bit index counts device falling edges. On each clk_fall the next bit is presented, with ps2_data_oe = ~bit:
  - falls 1..8: data bits D0..D7, LSB first (state DATA)
  - fall 9: parity bit (state PARITY)
  - fall 10: stop bit, data released (state STOP)
  - fall 11: synced ps2_data is sampled (state ACK). 0 -> ack_ok pulse; 1 -> ack_err pulse. Then -> WAIT_IDLE.
- Timeout: in REQ/DATA/PARITY/STOP/ACK the counter clears on each clk_fall. If it reaches TIMEOUT_CYCLES-1: release both lines the next cycle, pulse ack_err, -> WAIT_IDLE.
- WAIT_IDLE: lines released. When both synced lines are 1 in the same cycle -> IDLE; tx_ready is 1 the following cycle.
- Exactly one of ack_ok/ack_err pulses per accepted byte, never both. The only exception is clr mid-transfer, which pulses neither.
- Reset mid-operation: oe outputs drop asynchronously, the latched byte is discarded, and no pulse is generated.
- Counter saturates and never wraps.

Decomposition:
- Package ps2_pkg: state enum (IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE), constant NUM_FALLS = 11, default cycle constants. The package is shared with the keyboard receiver.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detect, one instance per line. It is reusable by the receiver.

Test Plan:
- Reset values: clr high -> both oe 0, tx_ready/busy/ack_ok/ack_err 0; first clk after release -> tx_ready 1.
- Send 0xED with a device model clocking at 12.5 kHz and ACKing:
  - ps2_clk_oe held exactly 5760 clocks; data_oe rises on the last of them.
  - Bits presented 1,0,1,1,0,1,1,1, then parity 1, then stop released.
  - ack_ok pulses once; tx_ready returns 1 after the lines go idle.
- Send 0x00 with a device that does not ACK (data high at fall 11) -> parity bit 1 presented, ack_err single pulse, ack_ok stays 0.
- With TIMEOUT_CYCLES = 2000, the device stops clocking after fall 4 -> exactly 2000 clocks after the last fall both oe are 0 and ack_err pulses; the block returns to IDLE once the lines read 1.
- clr asserted during DATA (after fall 5) -> oe outputs 0 combinationally-async with no clock edge; no ack pulse; the next byte is sent correctly from INHIBIT.
- tx_valid held with 0xED, then 0x02 back-to-back -> 0x02 is not accepted until tx_ready returns after the first ACK; both bytes appear on the wire in order and two ack_ok pulses are seen.
